// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : shared types and constants for the LCD 4-bit bus driver.
// Feature macro: LCD_POWERON_INIT_EN adds the power-on init states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

  localparam int CNT_W = 20;

  localparam int C_T_SETUP    = 2;
  localparam int C_T_PULSE    = 12;
  localparam int C_T_HOLD     = 1;
  localparam int C_T_GAP      = 50;
  localparam int C_T_CMD_WAIT = 2000;
  localparam int C_T_PWR_ON   = 750000;
  localparam int C_T_INIT1    = 205000;
  localparam int C_T_INIT2    = 5000;

  localparam int DB_RS       = 9;
  localparam int DB_RW       = 8;
  localparam int DB_DATA_MSB = 7;
  localparam int DB_DATA_LSB = 0;

  localparam logic [3:0] C_NIB_WAKE  = 4'h3;
  localparam logic [3:0] C_NIB_FINAL = 4'h2;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LATCH    = 4'd1,
    ST_HI_SETUP = 4'd2,
    ST_HI_PULSE = 4'd3,
    ST_HI_HOLD  = 4'd4,
    ST_GAP      = 4'd5,
    ST_LO_SETUP = 4'd6,
    ST_LO_PULSE = 4'd7,
    ST_LO_HOLD  = 4'd8,
    ST_CMD_WAIT = 4'd9,
    ST_DONE     = 4'd10
`ifdef LCD_POWERON_INIT_EN
    ,
    ST_INIT       = 4'd11,
    ST_INIT_SETUP = 4'd12,
    ST_INIT_PULSE = 4'd13,
    ST_INIT_HOLD  = 4'd14,
    ST_INIT_WAIT  = 4'd15
`endif
  } state_t;

  // Three wake-up nibbles followed by the switch to 4-bit mode.
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? C_NIB_FINAL : C_NIB_WAKE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_delay_counter.sv
// ============================================================================
// lcd_delay_counter : loadable down-counter with zero flag, shared by all
// timed states of the LCD bus driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_delay_counter #(
  parameter int               WIDTH   = 20,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_bus_driver.sv
// ============================================================================
// lcd_bus_driver : executes one {RS,RW,D[7:0]} instruction as two nibble
// writes on a 4-bit HD44780 bus. Optional macro: LCD_POWERON_INIT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int T_SETUP    = C_T_SETUP,
  parameter int T_PULSE    = C_T_PULSE,
  parameter int T_HOLD     = C_T_HOLD,
  parameter int T_GAP      = C_T_GAP,
  parameter int T_CMD_WAIT = C_T_CMD_WAIT
`ifdef LCD_POWERON_INIT_EN
  ,
  parameter int T_PWR_ON   = C_T_PWR_ON,
  parameter int T_INIT1    = C_T_INIT1,
  parameter int T_INIT2    = C_T_INIT2
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] db,
  output logic       done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  // Counter loads duration-1 so a state lasts exactly its duration.
  localparam logic [CNT_W-1:0] c_ld_setup = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] c_ld_pulse = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] c_ld_hold  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] c_ld_gap   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] c_ld_cmd   = CNT_W'(T_CMD_WAIT - 1);

`ifdef LCD_POWERON_INIT_EN
  localparam state_t           c_rst_state = ST_INIT;
  localparam logic             c_rst_busy  = 1'b1;
  localparam logic [CNT_W-1:0] c_rst_cnt   = CNT_W'(T_PWR_ON - 1);
`else
  localparam state_t           c_rst_state = ST_IDLE;
  localparam logic             c_rst_busy  = 1'b0;
  localparam logic [CNT_W-1:0] c_rst_cnt   = '0;
`endif

  state_t           r_state, w_next;
  logic [9:0]       r_db, w_src;
  logic             w_load, w_zero, w_hi, w_lo, w_init_win;
  logic [CNT_W-1:0] w_load_val;
  logic [3:0]       w_d_nx;
  logic             w_rs_nx, w_rw_nx;
  logic             r_e, r_rs, r_rw, r_done, r_busy;
  logic [3:0]       r_d;
`ifdef LCD_POWERON_INIT_EN
  logic [1:0]       r_init_idx, w_idx_nx;
`endif

  lcd_delay_counter #(
    .WIDTH   (CNT_W),
    .RST_VAL (c_rst_cnt)
  ) u_delay (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (r_state != ST_IDLE),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_rst_state;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
`ifdef LCD_POWERON_INIT_EN
    w_idx_nx   = r_init_idx;
`endif
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_LATCH;
      ST_LATCH:    begin w_next = ST_HI_SETUP; w_load = 1'b1; w_load_val = c_ld_setup; end
      ST_HI_SETUP: if (w_zero) begin w_next = ST_HI_PULSE; w_load = 1'b1; w_load_val = c_ld_pulse; end
      ST_HI_PULSE: if (w_zero) begin w_next = ST_HI_HOLD;  w_load = 1'b1; w_load_val = c_ld_hold;  end
      ST_HI_HOLD:  if (w_zero) begin w_next = ST_GAP;      w_load = 1'b1; w_load_val = c_ld_gap;   end
      ST_GAP:      if (w_zero) begin w_next = ST_LO_SETUP; w_load = 1'b1; w_load_val = c_ld_setup; end
      ST_LO_SETUP: if (w_zero) begin w_next = ST_LO_PULSE; w_load = 1'b1; w_load_val = c_ld_pulse; end
      ST_LO_PULSE: if (w_zero) begin w_next = ST_LO_HOLD;  w_load = 1'b1; w_load_val = c_ld_hold;  end
      ST_LO_HOLD:  if (w_zero) begin w_next = ST_CMD_WAIT; w_load = 1'b1; w_load_val = c_ld_cmd;   end
      ST_CMD_WAIT: if (w_zero) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
`ifdef LCD_POWERON_INIT_EN
      ST_INIT:       if (w_zero) begin w_next = ST_INIT_SETUP; w_load = 1'b1; w_load_val = c_ld_setup; end
      ST_INIT_SETUP: if (w_zero) begin w_next = ST_INIT_PULSE; w_load = 1'b1; w_load_val = c_ld_pulse; end
      ST_INIT_PULSE: if (w_zero) begin w_next = ST_INIT_HOLD;  w_load = 1'b1; w_load_val = c_ld_hold;  end
      ST_INIT_HOLD: begin
        if (w_zero) begin
          w_next = ST_INIT_WAIT;
          w_load = 1'b1;
          case (r_init_idx)
            2'd0:    w_load_val = CNT_W'(T_INIT1 - 1);
            2'd1:    w_load_val = CNT_W'(T_INIT2 - 1);
            default: w_load_val = c_ld_cmd;
          endcase
        end
      end
      ST_INIT_WAIT: begin
        if (w_zero) begin
          if (r_init_idx == 2'd3) begin
            w_next = ST_IDLE;
          end else begin
            w_next     = ST_INIT_SETUP;
            w_load     = 1'b1;
            w_load_val = c_ld_setup;
            w_idx_nx   = r_init_idx + 2'd1;
          end
        end
      end
`endif
      default:     w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pin changes on the
  // same edge that enters the corresponding state.
  assign w_src = (r_state == ST_LATCH) ? db : r_db;
  assign w_hi  = (w_next == ST_HI_SETUP) || (w_next == ST_HI_PULSE) || (w_next == ST_HI_HOLD);
  assign w_lo  = (w_next == ST_LO_SETUP) || (w_next == ST_LO_PULSE) || (w_next == ST_LO_HOLD);
`ifdef LCD_POWERON_INIT_EN
  assign w_init_win = (w_next == ST_INIT_SETUP) || (w_next == ST_INIT_PULSE) ||
                      (w_next == ST_INIT_HOLD);
`else
  assign w_init_win = 1'b0;
`endif

  always_comb begin
    w_d_nx  = 4'h0;
    w_rs_nx = 1'b0;
    w_rw_nx = 1'b0;
    if (w_hi || w_lo) begin
      w_d_nx  = w_hi ? w_src[DB_DATA_MSB -: 4] : w_src[DB_DATA_LSB +: 4];
      w_rs_nx = w_src[DB_RS];
      w_rw_nx = w_src[DB_RW];
    end else if (w_init_win) begin
`ifdef LCD_POWERON_INIT_EN
      w_d_nx  = init_nibble(w_idx_nx);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_db   <= '0;
      r_e    <= 1'b0;
      r_rs   <= 1'b0;
      r_rw   <= 1'b0;
      r_d    <= 4'h0;
      r_done <= 1'b0;
      r_busy <= c_rst_busy;
`ifdef LCD_POWERON_INIT_EN
      r_init_idx <= 2'd0;
`endif
    end else begin
      if (r_state == ST_LATCH) r_db <= db;
      r_e    <= (w_next == ST_HI_PULSE) || (w_next == ST_LO_PULSE)
`ifdef LCD_POWERON_INIT_EN
                || (w_next == ST_INIT_PULSE)
`endif
                ;
      r_rs   <= w_rs_nx;
      r_rw   <= w_rw_nx;
      r_d    <= w_d_nx;
      r_done <= (w_next == ST_DONE);
      r_busy <= (w_next != ST_IDLE);
`ifdef LCD_POWERON_INIT_EN
      r_init_idx <= w_idx_nx;
`endif
    end
  end

  assign done   = r_done;
  assign busy   = r_busy;
  assign lcd_e  = r_e;
  assign lcd_rs = r_rs;
  assign lcd_rw = r_rw;
  assign lcd_d  = r_d;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_driver.sv
// ============================================================================
// tb_lcd_bus_driver : self-checking bench for lcd_bus_driver.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lcd_bus_driver;

  localparam int TS = 2;
  localparam int TP = 12;
  localparam int TH = 1;
  localparam int TG = 50;
`ifdef LCD_POWERON_INIT_EN
  localparam int TC   = 10;
  localparam int TPWR = 100;
  localparam int TI1  = 40;
  localparam int TI2  = 20;
  localparam logic INIT_EN = 1'b1;
`else
  localparam int TC = 2000;
  localparam logic INIT_EN = 1'b0;
`endif
  localparam int DN = 1 + 2 * (TS + TP + TH) + TG + TC + 1;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [9:0] db;
  logic       done, busy, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_bus_driver #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG), .T_CMD_WAIT(TC)
`ifdef LCD_POWERON_INIT_EN
    , .T_PWR_ON(TPWR), .T_INIT1(TI1), .T_INIT2(TI2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .db(db), .done(done), .busy(busy),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt  = 0;
  int last_done = -1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) begin done_cnt++; last_done = cyc; end

  typedef struct { int k; logic [8:0] exp; } vec_t;
  vec_t tab[17];

  function automatic logic [8:0] pk(logic e, logic rs, logic rw, logic [3:0] d,
                                    logic bz, logic dn);
    return {e, rs, rw, d, bz, dn};
  endfunction

  // Reference timeline for an instruction whose start strobe is at cycle 0.
  function automatic logic [8:0] model_out(int k, logic [9:0] d);
    int hs = 2;
    int hp = hs + TS;
    int hh = hp + TP;
    int gp = hh + TH;
    int ls = gp + TG;
    int lp = ls + TS;
    int lh = lp + TP;
    int cw = lh + TH;
    logic hw, lw, e;
    logic [3:0] nib;
    hw  = (k >= hs) && (k < gp);
    lw  = (k >= ls) && (k < cw);
    e   = ((k >= hp) && (k < hh)) || ((k >= lp) && (k < lh));
    nib = hw ? d[7:4] : (lw ? d[3:0] : 4'h0);
    return pk(e, (hw || lw) && d[9], (hw || lw) && d[8], nib,
              (k >= 1) && (k <= DN), k == DN);
  endfunction

  function automatic bit is_cp(int k);
    int b[11];
    b = '{0, 1, 2, 2 + TS, 2 + TS + TP, 2 + TS + TP + TH, 2 + TS + TP + TH + TG,
          4 + 2 * TS + TP + TH + TG, 4 + 2 * TS + 2 * TP + TH + TG,
          4 + 2 * (TS + TP + TH) + TG, DN};
    foreach (b[i]) if (k == b[i] || k == b[i] - 1) return 1'b1;
    return (k % 300) == 150;
  endfunction

  task automatic check(input string name, input logic [8:0] exp_v);
    logic [8:0] act;
    act = {lcd_e, lcd_rs, lcd_rw, lcd_d, busy, done};
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: e/rs/rw/d/busy/done got %b expected %b", name, act, exp_v);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from the current cycle; returns in cycle DN+1.
  task automatic run_instr(input logic [9:0] d, input int stray, input bit use_tab,
                           input string tag);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k <= DN; k++) begin
      start = (k == 0) || (k == stray);
      if (k == 0) db = d;
      else if (k >= 2) db = 10'($urandom);
      @(negedge clk);
      if (use_tab) begin
        foreach (tab[i]) if (tab[i].k == k) check($sformatf("%s c%0d", tag, k), tab[i].exp);
      end else if (is_cp(k)) begin
        check($sformatf("%s c%0d", tag, k), model_out(k, d));
      end
      tick();
    end
    start = 1'b0;
    check_int({tag, " done count"}, done_cnt - d0, 1);
  endtask

  // Called in the first cycle with reset low.
  task automatic after_reset(input string tag);
`ifdef LCD_POWERON_INIT_EN
    int s[4];
    int w[4];
    int endc;
    logic e;
    logic [3:0] nib;
    w = '{TI1, TI2, TC, TC};
    s[0] = TPWR;
    for (int i = 1; i < 4; i++) s[i] = s[i-1] + TS + TP + TH + w[i-1];
    endc = s[3] + TS + TP + TH + w[3];
    for (int k = 0; k <= endc; k++) begin
      start = (k == TPWR / 2) || (k == s[1] + TS);
      db    = 10'($urandom);
      @(negedge clk);
      e = 1'b0;
      nib = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (k >= s[i] && k < s[i] + TS + TP + TH) nib = (i == 3) ? 4'h2 : 4'h3;
        if (k >= s[i] + TS && k < s[i] + TS + TP) e = 1'b1;
      end
      check($sformatf("%s init c%0d", tag, k), pk(e, 1'b0, 1'b0, nib, k < endc, 1'b0));
      tick();
    end
    start = 1'b0;
`else
    @(negedge clk);
    check({tag, " idle after reset"}, 9'b0);
    tick();
`endif
  endtask

  initial begin
    int l1, l2, d0, stray;

    tab[0]  = '{0,    9'b0_0_0_0000_0_0};
    tab[1]  = '{1,    9'b0_0_0_0000_1_0};
    tab[2]  = '{2,    9'b0_0_0_0010_1_0};
    tab[3]  = '{3,    9'b0_0_0_0010_1_0};
    tab[4]  = '{4,    9'b1_0_0_0010_1_0};
    tab[5]  = '{15,   9'b1_0_0_0010_1_0};
    tab[6]  = '{16,   9'b0_0_0_0010_1_0};
    tab[7]  = '{17,   9'b0_0_0_0000_1_0};
    tab[8]  = '{66,   9'b0_0_0_0000_1_0};
    tab[9]  = '{67,   9'b0_0_0_1000_1_0};
    tab[10] = '{69,   9'b1_0_0_1000_1_0};
    tab[11] = '{80,   9'b1_0_0_1000_1_0};
    tab[12] = '{81,   9'b0_0_0_1000_1_0};
    tab[13] = '{82,   9'b0_0_0_0000_1_0};
    tab[14] = '{2081, 9'b0_0_0_0000_1_0};
    tab[15] = '{2082, 9'b0_0_0_0000_1_1};
    tab[16] = '{68,   9'b0_0_0_1000_1_0};

    reset = 1'b1;
    start = 1'b0;
    db    = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset state", pk(1'b0, 1'b0, 1'b0, 4'h0, INIT_EN, 1'b0));
    tick();
    reset = 1'b0;
    after_reset("powerup");

`ifdef LCD_POWERON_INIT_EN
    run_instr(10'h028, -1, 1'b0, "t1");
`else
    run_instr(10'h028, -1, 1'b1, "t1");
`endif
    run_instr(10'h241, -1, 1'b0, "t2");
    run_instr(10'h155, (DN > 500) ? 500 : DN / 2, 1'b0, "t3 stray mid");
    run_instr(10'h2AA, DN, 1'b0, "t3 stray done");

    run_instr(10'h001, -1, 1'b0, "t5a");
    l1 = last_done;
    run_instr(10'h080, -1, 1'b0, "t5b");
    l2 = last_done;
    check_int("t5 back-to-back spacing", l2 - l1, DN + 1);

    // Reset while the high nibble is being strobed.
    d0    = done_cnt;
    start = 1'b1;
    db    = 10'h0F5;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    reset = 1'b1;
    @(negedge clk);
    check("t4 before reset c10", model_out(10, 10'h0F5));
    tick();
    reset = 1'b0;
    after_reset("t4");
`ifndef LCD_POWERON_INIT_EN
    repeat (DN + 20) tick();
`endif
    check_int("t4 no done after reset", done_cnt - d0, 0);

    for (int i = 0; i < 8; i++) begin
      stray = $urandom_range(DN, 2);
      run_instr(10'($urandom), stray, 1'b0, $sformatf("rand%0d", i));
    end

    @(negedge clk);
    check("final idle", 9'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
